// File: rtl/lamp_frame_ctrl_pkg.sv
// Shared types and default constants for the LED frame controller.
// Build macro: LAMP_REFRESH_EN (autonomous refresh timer in the top).
package lamp_pkg;

  localparam int C_FREQ       = 20_000_000;
  localparam int C_SCLK_FREQ  = 1_000_000;
  localparam int C_CHANNELS   = 12;
  localparam int C_BITS       = 16;
  localparam int C_REFRESH_HZ = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } lamp_state_t;

  function automatic int half_div(input int f, input int s);
    return f / (2 * s);
  endfunction

endpackage

// File: rtl/lamp_frame_ctrl_if.sv
// Host-side bundle for the frame controller: shadow writes,
// frame request and frame status.
interface lamp_frame_ctrl_if #(
  parameter int c_aw = 4,
  parameter int c_bw = 16
);

  logic            wr_en;
  logic [c_aw-1:0] wr_addr;
  logic [c_bw-1:0] wr_data;
  logic            start;
  logic            busy;
  logic            done;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done
  );

endinterface

// File: rtl/lamp_frame_ctrl_tick.sv
// Half-period tick generator for the serial LED clock.
// Pulses once every c_div cycles; i_clr holds it at phase zero.
module lamp_tick #(
  parameter int c_div = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int c_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_w-1:0] c_max = c_w'(c_div - 1);

  logic [c_w-1:0] r_cnt;

  assign o_tick = !i_clr && (r_cnt == c_max);

  // divide counter, wraps at c_div and restarts on clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clr || r_cnt == c_max)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/lamp_frame_ctrl.sv
// Shadow-register LED frame controller driving a serial driver chain.
// Build macro: LAMP_REFRESH_EN adds an autonomous refresh timer.
module lamp_frame_ctrl
  import lamp_pkg::*;
#(
  parameter int c_freq       = C_FREQ,
  parameter int c_sclk_freq  = C_SCLK_FREQ,
  parameter int c_channels   = C_CHANNELS,
  parameter int c_bits       = C_BITS,
  parameter int c_refresh_hz = C_REFRESH_HZ,
  localparam int c_aw = (c_channels > 1) ? $clog2(c_channels) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [c_aw-1:0]   i_wr_addr,
  input  logic [c_bits-1:0] i_wr_data,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_clk,
  output logic              o_dai,
  output logic              o_lat
);

  localparam int c_half  = half_div(c_freq, c_sclk_freq);
  localparam int c_nbits = c_channels * c_bits;
  localparam int c_bw    = $clog2(c_nbits + 1);
  localparam logic [c_bw-1:0] c_last = c_bw'(c_nbits - 1);

  lamp_state_t       r_state;
  lamp_state_t       w_next;
  logic [c_bits-1:0] r_shadow [c_channels];
  logic [c_nbits-1:0] r_buf;
  logic [c_nbits-1:0] w_pack;
  logic [c_bw-1:0]   r_bit;
  logic              r_phase;
  logic              r_sclk;
  logic              r_pend;
  logic              r_done;
  logic              w_tick;
  logic              w_clr;
  logic              w_auto;
  logic              w_req;

`ifdef LAMP_REFRESH_EN
  localparam int c_rper = c_freq / c_refresh_hz;
  localparam int c_rw   = $clog2(c_rper);
  localparam logic [c_rw-1:0] c_rmax = c_rw'(c_rper - 1);

  logic [c_rw-1:0] r_rcnt;

  assign w_auto = (r_rcnt == c_rmax);

  // free-running refresh period counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rcnt <= '0;
    else if (r_rcnt == c_rmax)
      r_rcnt <= '0;
    else
      r_rcnt <= r_rcnt + 1'b1;
  end
`else
  assign w_auto = 1'b0;
`endif

  assign w_req = i_start | w_auto;
  assign w_clr = (r_state == S_IDLE) || (r_state == S_LOAD);

  lamp_tick #(.c_div(c_half)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // channel c_channels-1 lands in the top bits so it leaves first
  always_comb begin
    w_pack = '0;
    for (int i = 0; i < c_channels; i++)
      w_pack[i*c_bits +: c_bits] = r_shadow[i];
  end

  // shadow register file, out-of-range addresses dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < c_channels; i++)
        r_shadow[i] <= '0;
    end else if (i_wr_en && int'(i_wr_addr) < c_channels) begin
      r_shadow[i_wr_addr] <= i_wr_data;
    end
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // next-state: each bit and each of LATCH/GAP spans two ticks
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req || r_pend) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_tick && r_phase && r_bit == c_last)
                 w_next = S_LATCH;
      S_LATCH: if (w_tick && r_phase) w_next = S_GAP;
      S_GAP:   if (w_tick && r_phase) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // frame datapath: snapshot, shift, serial clock, pending, done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_GAP) && (w_next == S_IDLE);
      if (r_state == S_IDLE)
        r_pend <= 1'b0;
      else if (w_req)
        r_pend <= 1'b1;
      case (r_state)
        S_LOAD: begin
          r_buf   <= w_pack;
          r_bit   <= '0;
          r_phase <= 1'b0;
          r_sclk  <= 1'b0;
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_phase <= ~r_phase;
            r_sclk  <= ~r_phase;
            if (r_phase) begin
              r_buf <= {r_buf[c_nbits-2:0], 1'b0};
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        S_LATCH, S_GAP: begin
          if (w_tick)
            r_phase <= ~r_phase;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_clk  = r_sclk;
  assign o_lat  = (r_state == S_LATCH);
  assign o_dai  = (r_state == S_SHIFT) ? r_buf[c_nbits-1] : 1'b0;

endmodule

// File: tb/tb_lamp_frame_ctrl.sv
// Directed bench for lamp_frame_ctrl at default parameters.
// Refresh scenario only runs when LAMP_REFRESH_EN is defined.
module tb_lamp_frame_ctrl;

  localparam int NB = 192;
  localparam int FRAME = 3882;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  lamp_frame_ctrl_if #(.c_aw(4), .c_bw(16)) bus ();

  logic o_clk, o_dai, o_lat;

  lamp_frame_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_start   (bus.start),
    .o_busy    (bus.busy),
    .o_done    (bus.done),
    .o_clk     (o_clk),
    .o_dai     (o_dai),
    .o_lat     (o_lat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bit   bits_q [$];
  int   done_q [$];
  int   busy_q [$];
  int   lat_n = 0;
  int   viol_n = 0;
  logic p_clk = 1'b0;
  logic p_dai = 1'b0;
  logic p_busy = 1'b0;

  always @(negedge clk) begin
    if (o_clk && !p_clk) bits_q.push_back(o_dai);
    if (o_clk && o_dai !== p_dai) viol_n++;
    if (o_lat) begin
      lat_n++;
      if (o_clk) viol_n++;
    end
    if ((o_lat || !bus.busy) && o_dai) viol_n++;
    if (bus.done) done_q.push_back(cyc);
    if (bus.busy && !p_busy) busy_q.push_back(cyc);
    p_clk  = o_clk;
    p_dai  = o_dai;
    p_busy = bus.busy;
  end

  task automatic wr(input int a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(output int t0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim, output bit ok);
    for (int i = 0; i < lim && done_q.size() < n; i++)
      @(negedge clk);
    ok = (done_q.size() >= n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] word_at(input int b);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (b + i < bits_q.size()) w[15-i] = bits_q[b + i];
    return w;
  endfunction

  function automatic int ones_in(input int b, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++)
      if (b + i < bits_q.size() && bits_q[b + i]) c++;
    return c;
  endfunction

  task automatic test_reset;
    logic [4:0] o;
    rst_n = 1'b0;
    idle(3);
    o = {bus.busy, bus.done, o_clk, o_dai, o_lat};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 00000", o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_frame;
    int t0, bb, db, bub, lb, vb, v;
    bit ok;
    wr(11, 16'hA5A5);
    bb = bits_q.size();
    db = done_q.size();
    bub = busy_q.size();
    lb = lat_n;
    vb = viol_n;
    do_start(t0);
    wait_done(db + 1, 5000, ok);
    idle(4);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: got no done expected done");
    end
    v = (busy_q.size() > bub) ? busy_q[bub] - t0 : -1;
    checks++;
    if (v !== 1) begin
      errors++;
      $display("FAIL busy_latency: got %0d expected 1", v);
    end
    v = (done_q.size() > db) ? done_q[db] - t0 : -1;
    checks++;
    if (v !== FRAME) begin
      errors++;
      $display("FAIL done_latency: got %0d expected %0d", v, FRAME);
    end
    checks++;
    if (done_q.size() - db !== 1) begin
      errors++;
      $display("FAIL done_count: got %0d expected 1", done_q.size() - db);
    end
    checks++;
    if (lat_n - lb !== 20) begin
      errors++;
      $display("FAIL lat_width: got %0d expected 20", lat_n - lb);
    end
    checks++;
    if (bits_q.size() - bb !== NB) begin
      errors++;
      $display("FAIL bit_count: got %0d expected %0d", bits_q.size() - bb, NB);
    end
    checks++;
    if (word_at(bb) !== 16'hA5A5) begin
      errors++;
      $display("FAIL first_word: got %h expected a5a5", word_at(bb));
    end
    checks++;
    if (ones_in(bb + 16, NB - 16) !== 0) begin
      errors++;
      $display("FAIL tail_zero: got %0d ones expected 0", ones_in(bb + 16, NB - 16));
    end
    checks++;
    if (viol_n - vb !== 0) begin
      errors++;
      $display("FAIL serial_rules: got %0d violations expected 0", viol_n - vb);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_write_during_shift;
    int t0, bb, db;
    bit ok;
    bb = bits_q.size();
    db = done_q.size();
    do_start(t0);
    idle(200);
    wr(11, 16'hFFFF);
    wr(0, 16'h8001);
    wr(12, 16'h1234);
    wr(15, 16'h4321);
    wait_done(db + 1, 5000, ok);
    idle(2);
    checks++;
    if (!ok || word_at(bb) !== 16'hA5A5 || ones_in(bb + 16, NB - 16) !== 0) begin
      errors++;
      $display("FAIL snapshot_hold: got %h/%0d expected a5a5/0", word_at(bb), ones_in(bb + 16, NB - 16));
    end
    bb = bits_q.size();
    db = done_q.size();
    do_start(t0);
    wait_done(db + 1, 5000, ok);
    idle(2);
    checks++;
    if (!ok || word_at(bb) !== 16'hFFFF) begin
      errors++;
      $display("FAIL next_first: got %h expected ffff", word_at(bb));
    end
    checks++;
    if (word_at(bb + NB - 16) !== 16'h8001) begin
      errors++;
      $display("FAIL next_last: got %h expected 8001", word_at(bb + NB - 16));
    end
    checks++;
    if (ones_in(bb + 16, NB - 32) !== 0) begin
      errors++;
      $display("FAIL next_mid: got %0d ones expected 0", ones_in(bb + 16, NB - 32));
    end
  endtask

  task automatic test_back_to_back;
    int t0, db, bub, v;
    bit ok;
    db = done_q.size();
    bub = busy_q.size();
    do_start(t0);
    idle(100);
    for (int k = 0; k < 3; k++) begin
      do_start(v);
      idle(50);
    end
    wait_done(db + 2, 9000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d dones expected 2", done_q.size() - db);
    end
    v = (busy_q.size() > bub + 1 && done_q.size() > db) ? busy_q[bub + 1] - done_q[db] : -1;
    checks++;
    if (v !== 1) begin
      errors++;
      $display("FAIL pend_restart: got %0d expected 1", v);
    end
    v = (done_q.size() > db + 1) ? done_q[db + 1] - done_q[db] : -1;
    checks++;
    if (v !== FRAME) begin
      errors++;
      $display("FAIL pend_frame: got %0d expected %0d", v, FRAME);
    end
    idle(4500);
    checks++;
    if (done_q.size() - db !== 2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL merge_count: got %0d busy %b expected 2 busy 0", done_q.size() - db, bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    int t0, bb, db, lb;
    bit ok;
    logic [4:0] o;
    bb = bits_q.size();
    db = done_q.size();
    lb = lat_n;
    do_start(t0);
    for (int i = 0; i < 2000 && bits_q.size() - bb < 50; i++)
      @(negedge clk);
    checks++;
    if (bits_q.size() - bb < 50) begin
      errors++;
      $display("FAIL reach_bit50: got %0d expected 50", bits_q.size() - bb);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    o = {bus.busy, bus.done, o_clk, o_dai, o_lat};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL abort_outs: got %b expected 00000", o);
    end
    idle(3);
    rst_n = 1'b1;
    idle(5000);
    checks++;
    if (done_q.size() - db !== 0 || lat_n - lb !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got done %0d lat %0d expected 0 0", done_q.size() - db, lat_n - lb);
    end
    bb = bits_q.size();
    db = done_q.size();
    do_start(t0);
    wait_done(db + 1, 5000, ok);
    checks++;
    if (!ok || ones_in(bb, NB) !== 0) begin
      errors++;
      $display("FAIL shadow_cleared: got %0d ones expected 0", ones_in(bb, NB));
    end
    checks++;
    if (!ok || done_q[db] - t0 !== FRAME) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d expected %0d", ok ? done_q[db] - t0 : -1, FRAME);
    end
  endtask

`ifdef LAMP_REFRESH_EN
  task automatic test_refresh;
    int db, v;
    bit ok;
    idle(10);
    db = done_q.size();
    wait_done(db + 2, 500000, ok);
    v = ok ? done_q[db + 1] - done_q[db] : -1;
    checks++;
    if (v !== 200000) begin
      errors++;
      $display("FAIL refresh_period: got %0d expected 200000", v);
    end
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    test_reset();
    test_frame();
    test_write_during_shift();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef LAMP_REFRESH_EN
    test_refresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_frame_ctrl.md
LAMP_FRAME_CTRL -- requirements
Module: lamp_frame_ctrl

Interface
REQ-001 SHALL have parameter c_freq, default 20000000, system clock frequency in Hz.
REQ-002 SHALL have parameter c_sclk_freq, default 1000000, serial LED clock frequency in Hz.
REQ-003 SHALL have parameter c_channels, default 12, number of driver channels in the chain.
REQ-004 SHALL have parameter c_bits, default 16, bits per channel word.
REQ-005 SHALL have parameter c_refresh_hz, default 100, autonomous refresh rate in Hz.
REQ-006 SHALL have port i_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_wr_en, input, 1, shadow-register write strobe.
REQ-009 SHALL have port i_wr_addr, input, clog2(c_channels), channel index written.
REQ-010 SHALL have port i_wr_data, input, c_bits, channel value written.
REQ-011 SHALL have port i_start, input, 1, single-cycle frame transmit request.
REQ-012 SHALL have port o_busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port o_done, output, 1, single-cycle pulse at frame completion.
REQ-014 SHALL have ports o_clk, o_dai, o_lat, outputs, 1 each, serial clock, serial data and latch to the LED driver chain.

Function
REQ-015 SHALL write i_wr_data into shadow[i_wr_addr] on any cycle with i_wr_en high; writes with i_wr_addr >= c_channels SHALL be ignored.
REQ-016 SHALL derive a half-period tick every c_half = c_freq/(2*c_sclk_freq) cycles (10 at defaults), counter cleared on entry to LOAD.
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, LATCH, GAP; IDLE->LOAD on accepted start; LOAD->SHIFT after 1 cycle; SHIFT->LATCH after c_channels*c_bits bits; LATCH->GAP after 2 ticks; GAP->IDLE after 2 ticks.
REQ-018 In LOAD SHALL snapshot all shadow registers into the shift buffer; writes after LOAD SHALL NOT affect the current frame.
REQ-019 SHALL shift channel c_channels-1 first, MSB first; o_dai SHALL change only while o_clk is low, o_clk SHALL rise on the first tick of each bit and fall on the second.
REQ-020 o_lat SHALL be high for exactly the LATCH state (2*c_half cycles) with o_clk low; o_dai SHALL be 0 outside SHIFT.
REQ-021 o_busy SHALL be high in LOAD, SHIFT, LATCH, GAP; o_done SHALL pulse the cycle GAP->IDLE.
REQ-022 A start arriving when busy SHALL set one pending flag (further starts merged); pending SHALL cause IDLE->LOAD on the cycle after o_done and then clear.
REQ-023 i_start sampled at cycle T in IDLE SHALL give o_busy high at T+1 and o_done at T+1+1+c_channels*c_bits*2*c_half+4*c_half.

Reset
REQ-024 On i_rst_n low SHALL asynchronously enter IDLE with o_busy, o_done, o_clk, o_dai, o_lat = 0, pending clear, tick and bit counters 0, shadow registers 0.
REQ-025 Reset asserted mid-frame SHALL abort immediately; no o_done and no o_lat pulse SHALL follow release.

Configuration
REQ-026 With macro LAMP_REFRESH_EN defined SHALL include a refresh timer issuing an internal start every c_freq/c_refresh_hz cycles, merged with i_start per REQ-022; without it SHALL transmit only on i_start and contain no timer.

Structure
REQ-027 Shared package lamp_pkg SHALL hold the state enumeration and default constants (channels, bits, frequencies).
REQ-028 The half-period tick generator SHALL be sub-module lamp_tick (parameter divide ratio, outputs tick pulse, synchronous clear input).

Verification
REQ-029 Defaults, shadow[11]=16'hA5A5, others 0, start -> first 16 bits sampled on o_clk rising edges read A5A5, remaining 176 bits 0.
REQ-030 Start at T -> o_busy at T+1, o_lat high 20 cycles, o_done exactly at T+3882.
REQ-031 Write shadow[11]=16'hFFFF during SHIFT -> current frame unchanged; next frame sends FFFF.
REQ-032 Three starts during one busy frame -> exactly one further frame, o_done pulses twice total.
REQ-033 Reset pulsed at bit 50 -> all outputs 0 immediately, no o_lat or o_done until a new start.
REQ-034 With LAMP_REFRESH_EN, no i_start -> o_done every 200000 cycles.
